axi_lite_reg_worker: RTL



---
 rtl/axi_lite_reg_worker.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_reg_worker.sv
// AXI5-Lite worker endpoint: a bank of 32-bit read/write control registers.
// One outstanding write and one outstanding read; both paths run independently.
// Only AWADDR/ARADDR[ADDR_BITS-1:2] select a register. Upper bits alias.
//
// Optional feature macro: AXI_REG_WSTRB_EN
//   defined   : byte lane k is written only when WSTRB[k] is set
//   undefined : WSTRB is ignored and every accepted write replaces the full word
//
// Ports:
//   ACLK, ARESET              clock, asynchronous active-high reset
//   AW*/W*/B*                 write address, write data and write response channels
//   AR*/R*                    read address and read data channels
//   reg_q                     live register contents; reg i is at [32i+31:32i]
//   wr_pulse                  one-cycle strobe in the cycle after reg i is written
module axi_lite_reg_worker #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned ID_W      = 4,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [31:0]                         AWADDR,
    input  logic [2:0]                          AWPROT,
    input  logic [2:0]                          AWSIZE,
    input  logic [ID_W-1:0]                     AWID,
    input  logic                                AWVALID,
    output logic                                AWREADY,
    input  logic [31:0]                         WDATA,
    input  logic [3:0]                          WSTRB,
    input  logic                                WVALID,
    output logic                                WREADY,
    output logic [1:0]                          BRESP,
    output logic [ID_W-1:0]                     BID,
    output logic                                BVALID,
    input  logic                                BREADY,
    input  logic [31:0]                         ARADDR,
    input  logic [2:0]                          ARPROT,
    input  logic [2:0]                          ARSIZE,
    input  logic [ID_W-1:0]                     ARID,
    input  logic                                ARVALID,
    output logic                                ARREADY,
    output logic [31:0]                         RDATA,
    output logic [1:0]                          RRESP,
    output logic [ID_W-1:0]                     RID,
    output logic                                RVALID,
    input  logic                                RREADY,
    output logic [(32 << (ADDR_BITS-2))-1:0]    reg_q,
    output logic [(1 << (ADDR_BITS-2))-1:0]     wr_pulse
);

    localparam int unsigned IDX_W    = ADDR_BITS - 2;
    localparam int unsigned NUM_REGS = 1 << IDX_W;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [2:0]  MAX_SIZE    = 3'b010;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_RESP} rstate_t;

    logic [NUM_REGS-1:0][31:0] r_regs;
    wstate_t                   r_wstate;
    rstate_t                   r_rstate;

    logic [IDX_W-1:0]          r_aw_idx;
    logic [ID_W-1:0]           r_aw_id;
    logic                      r_aw_err;
    logic [31:0]               r_w_data;
    logic [3:0]                r_w_strb;

    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic [ID_W-1:0]           r_bid;
    logic [NUM_REGS-1:0]       r_wr_pulse;

    logic                      r_rvalid;
    logic [1:0]                r_rresp;
    logic [ID_W-1:0]           r_rid;
    logic [31:0]               r_rdata;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_commit;
    logic                      w_aw_live;
    logic                      w_w_live;
    logic [IDX_W-1:0]          w_idx;
    logic [ID_W-1:0]           w_id;
    logic                      w_err;
    logic [31:0]               w_data;
    logic [3:0]                w_strb;
    logic [31:0]               w_new_word;
    logic [IDX_W-1:0]          w_ar_idx;
    logic                      w_ar_err;
    logic                      w_unused;

    assign AWREADY = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_W);
    assign WREADY  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_AW);
    assign ARREADY = (r_rstate == R_IDLE);

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;

    // The write completes on whichever edge supplies the last missing half.
    assign w_commit = ((r_wstate == W_IDLE)    && w_aw_hs && w_w_hs) ||
                      ((r_wstate == W_HAVE_AW) && w_w_hs) ||
                      ((r_wstate == W_HAVE_W)  && w_aw_hs);

    // Take each half from the live channel unless it was latched earlier.
    assign w_aw_live = (r_wstate != W_HAVE_AW);
    assign w_w_live  = (r_wstate != W_HAVE_W);
    assign w_idx     = w_aw_live ? AWADDR[ADDR_BITS-1:2] : r_aw_idx;
    assign w_id      = w_aw_live ? AWID : r_aw_id;
    assign w_err     = w_aw_live ? (AWSIZE > MAX_SIZE) : r_aw_err;
    assign w_data    = w_w_live ? WDATA : r_w_data;
    assign w_strb    = w_w_live ? WSTRB : r_w_strb;

`ifdef AXI_REG_WSTRB_EN
    // Byte-lane merge of new data into the current register value.
    always_comb begin
        w_new_word = r_regs[w_idx];
        for (int k = 0; k < 4; k++) begin
            if (w_strb[k]) begin
                w_new_word[8*k +: 8] = w_data[8*k +: 8];
            end
        end
    end
    assign w_unused = ^{AWADDR[31:ADDR_BITS], AWADDR[1:0], ARADDR[31:ADDR_BITS],
                        ARADDR[1:0], AWPROT, ARPROT};
`else
    assign w_new_word = w_data;
    assign w_unused   = ^{AWADDR[31:ADDR_BITS], AWADDR[1:0], ARADDR[31:ADDR_BITS],
                          ARADDR[1:0], AWPROT, ARPROT, w_strb};
`endif

    assign w_ar_idx = ARADDR[ADDR_BITS-1:2];
    assign w_ar_err = (ARSIZE > MAX_SIZE);

    // Write FSM, register bank and B channel.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_regs     <= {NUM_REGS{RESET_VAL}};
            r_wstate   <= W_IDLE;
            r_aw_idx   <= '0;
            r_aw_id    <= '0;
            r_aw_err   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_bid      <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
                r_bid    <= w_id;
                if (!w_err) begin
                    r_regs[w_idx] <= w_new_word;
                    r_wr_pulse    <= NUM_REGS'(1) << w_idx;
                end
            end
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wstate <= W_RESP;
                    end else if (w_aw_hs) begin
                        r_wstate <= W_HAVE_AW;
                        r_aw_idx <= AWADDR[ADDR_BITS-1:2];
                        r_aw_id  <= AWID;
                        r_aw_err <= (AWSIZE > MAX_SIZE);
                    end else if (w_w_hs) begin
                        r_wstate <= W_HAVE_W;
                        r_w_data <= WDATA;
                        r_w_strb <= WSTRB;
                    end
                end
                W_HAVE_AW: if (w_w_hs)  r_wstate <= W_RESP;
                W_HAVE_W:  if (w_aw_hs) r_wstate <= W_RESP;
                W_RESP: begin
                    if (BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM and R channel; reads sample the bank before any same-edge write.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rid    <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (ARVALID) begin
                        r_rstate <= R_RESP;
                        r_rvalid <= 1'b1;
                        r_rid    <= ARID;
                        r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
                        r_rdata  <= w_ar_err ? 32'h0 : r_regs[w_ar_idx];
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign BVALID   = r_bvalid;
    assign BRESP    = r_bresp;
    assign BID      = r_bid;
    assign RVALID   = r_rvalid;
    assign RRESP    = r_rresp;
    assign RID      = r_rid;
    assign RDATA    = r_rdata;
    assign reg_q    = r_regs;
    assign wr_pulse = r_wr_pulse;

endmodule
